inst_loader: RTL and testbench
==============================

# inst_loader

Serial program loader for the monocycle CPU's 32-word instruction memory. It accepts a byte stream carrying a word count, little-endian instruction words and an XOR checksum. It assembles the words and writes them into the instruction RAM through the RAM's write port. It holds the CPU in reset until a load completes with a valid checksum.

## Interface
Parameters:
- ADDR_W, 5, instruction RAM word-address width; depth = 2^ADDR_W (32 matches pc_addr[4:0])
- DATA_W, 32, instruction word width; fixed at 32, 4 bytes per word

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins a load when in IDLE
- byte_valid  input  1  byte_data is valid this cycle
- byte_data  input  8  stream byte
- byte_ready  output  1  loader can accept a byte this cycle
- mem_we  output  1  instruction RAM write enable, one cycle per word
- mem_addr  output  ADDR_W  instruction RAM word address
- mem_wdata  output  DATA_W  instruction word to write
- cpu_hold  output  1  1 = CPU held in reset (drives the CPU's rst_n low externally)
- busy  output  1  load in progress (any state other than IDLE)
- done  output  1  one-cycle pulse on successful load
- err  output  1  sticky checksum-failure flag; cleared by the next accepted start or by rst

## Operation
- Byte transfer occurs when byte_valid && byte_ready.
- States and transitions:
  - IDLE: start → COUNT; clears err, clears the checksum accumulator and zeroes the word index. start while busy is ignored.
  - COUNT: accept 1 byte as N. N=0 means 2^ADDR_W words; values > 2^ADDR_W are truncated to ADDR_W bits, 0 → full depth. → DATA.
  - DATA: accept 4 bytes, with a byte counter 0..3. Byte k goes to word bits [8k+7:8k]. Each byte is XORed into the checksum. After the 4th byte → WRITE.
  - WRITE: one cycle. mem_we=1, mem_addr=word index, mem_wdata=assembled word. The index increments. If the last word was written → CHECK, else → DATA.
  - CHECK: accept 1 byte. If it equals the checksum → DONE. Otherwise set err=1 → IDLE.
  - DONE: one cycle, done=1, cpu_hold←0 → IDLE.
- Checksum = XOR of all 4N data bytes; the count byte is excluded.
- byte_ready=1 only in COUNT, DATA and CHECK. It is 0 in IDLE, WRITE and DONE, so a byte held valid across WRITE waits and is not dropped.
- cpu_hold is set to 1 on an accepted start and on rst. It is cleared only in DONE. A failed load leaves the CPU held.
- mem_addr and mem_wdata are registered. They hold their last value outside WRITE. mem_we is 0 outside WRITE.
- Word index wraps naturally at 2^ADDR_W. With N=0 the final write is at address 2^ADDR_W−1.

## Timing
- Reset values:
  - 1: cpu_hold
  - 0: byte_ready, mem_we, mem_addr, mem_wdata, busy, done, err
  - state IDLE; all counters and the checksum 0
- rst mid-load: the next cycle is IDLE with cpu_hold=1 and err=0. Words already written remain in RAM. No done pulse.
- start accepted in IDLE: the loader is in COUNT the next cycle, with byte_ready=1.
- mem_we asserts in the cycle after the 4th byte of a word is accepted.
- Minimum load with continuous byte_valid: 1 (start) + 1 (count) + 5N (4 bytes + WRITE) + 1 (check) + 1 (DONE) cycles.
- done and the deassertion of cpu_hold are registered together. cpu_hold is 0 in the cycle after DONE.
- busy is combinational from state. done and mem_we are single-cycle pulses.
- byte_valid=0 stalls any receiving state indefinitely. There is no timeout.

## Test plan
- Nominal 2-word load: start, bytes 02, 05 00 01 20, 00 00 00 00, 24 → mem_we at addr 0 with 0x20010005, then addr 1 with 0x00000000. done pulses once, cpu_hold 1→0, err=0.
- Bad checksum: same stream with final byte 25 → both writes still occur, err=1, no done, cpu_hold stays 1, busy=0. A following start clears err.
- Full depth: count byte 00, 128 bytes where word i = i → 32 writes at addresses 0..31, each with data i; last addr 31. Checksum accepted → done.
- Backpressure and gaps: byte_valid toggles randomly and is held high across WRITE → byte_ready=0 in WRITE, no byte lost or duplicated, written words bit-exact to the scoreboard.
- Reset mid-load: rst after 6 accepted bytes → next cycle IDLE, cpu_hold=1, no further mem_we. A subsequent nominal load succeeds.
- start pulses during DATA and CHECK → ignored; the load completes unchanged and only one done is produced.

Source files
------------

// File: rtl/inst_loader.sv
// Serial program loader: count byte, 4-byte LE words, XOR checksum -> instruction RAM writes.
// Latency: 1 (start) + 1 (count) + 5 per word + 1 (check) + 1 (done) cycles with a gapless stream.
// Backpressure: byte_ready only in COUNT/DATA/CHECK; bytes held valid across WRITE/DONE simply wait.
module inst_loader #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      S_IDLE, S_COUNT, S_DATA, S_WRITE, S_CHECK, S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;      // word count, 0 encodes full depth
   logic [ADDR_W-1:0]   idx_q, idx_d;      // next RAM word address
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [1:0]          bcnt_q, bcnt_d;    // byte position inside the current word
   logic [DATA_W-1:0]   word_q, word_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [7:0]          csum_q, csum_d;
   logic                hold_q, hold_d;
   logic                err_q, err_d;
   logic [ADDR_W-1:0]   last_idx;
   logic                xfer;

   // Index of the final word; count 0 wraps to all-ones, i.e. full depth
   assign last_idx = cnt_q - ADDR_W'(1);
   assign xfer     = byte_valid && byte_ready;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         addr_q  <= '0;
         bcnt_q  <= '0;
         word_q  <= '0;
         wdata_q <= '0;
         csum_q  <= '0;
         hold_q  <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         bcnt_q  <= bcnt_d;
         word_q  <= word_d;
         wdata_q <= wdata_d;
         csum_q  <= csum_d;
         hold_q  <= hold_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_COUNT;
         S_COUNT: if (xfer) state_d = S_DATA;
         S_DATA:  if (xfer && bcnt_q == 2'd3) state_d = S_WRITE;
         S_WRITE: state_d = (idx_q == last_idx) ? S_CHECK : S_DATA;
         S_CHECK: if (xfer) state_d = (byte_data == csum_q) ? S_DONE : S_IDLE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath updates: word assembly, checksum, RAM address/data staging, hold/err flags
   always_comb begin
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      bcnt_d  = bcnt_q;
      word_d  = word_q;
      wdata_d = wdata_q;
      csum_d  = csum_q;
      hold_d  = hold_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               err_d  = 1'b0;
               csum_d = '0;
               idx_d  = '0;
               bcnt_d = '0;
               hold_d = 1'b1;
            end
         end
         S_COUNT: begin
            if (xfer) cnt_d = byte_data[ADDR_W-1:0];
         end
         S_DATA: begin
            if (xfer) begin
               word_d[8*bcnt_q +: 8] = byte_data;
               csum_d                = csum_q ^ byte_data;
               bcnt_d                = bcnt_q + 2'd1;
               // Stage address/data now so they are stable during the WRITE cycle
               if (bcnt_q == 2'd3) begin
                  addr_d  = idx_q;
                  wdata_d = {byte_data, word_q[DATA_W-9:0]};
               end
            end
         end
         S_WRITE: idx_d = idx_q + ADDR_W'(1);
         S_CHECK: begin
            if (xfer && byte_data != csum_q) err_d = 1'b1;
         end
         S_DONE:  hold_d = 1'b0;
         default: ;
      endcase
   end

   // Outputs decoded from state plus registered flags
   always_comb begin
      byte_ready = (state_q == S_COUNT) || (state_q == S_DATA) || (state_q == S_CHECK);
      mem_we     = (state_q == S_WRITE);
      busy       = (state_q != S_IDLE);
      done       = (state_q == S_DONE);
      mem_addr   = addr_q;
      mem_wdata  = wdata_q;
      cpu_hold   = hold_q;
      err        = err_q;
   end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: nominal, bad checksum, full depth, gaps, reset mid-load, stray starts.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// A passive monitor logs every RAM write and done pulse for later comparison.
module tb_inst_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        byte_ready, mem_we, cpu_hold, busy, done, err;
   logic [4:0]  mem_addr;
   logic [31:0] mem_wdata;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int rdy_viol = 0;

   logic [4:0]  wa_q[$];
   logic [31:0] wd_q[$];
   logic [4:0]  ea[$];
   logic [31:0] ed[$];
   logic [7:0]  stream[$];

   inst_loader #(.ADDR_W(5), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .start(start),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Passive monitor: log writes and done pulses
   always @(negedge clk) begin
      if (mem_we) begin
         wa_q.push_back(mem_addr);
         wd_q.push_back(mem_wdata);
         if (byte_ready) rdy_viol++;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, input bit st);
      int t;
      if (gap > 0) begin
         byte_valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
      byte_valid = 1'b1;
      byte_data  = b;
      start      = st;
      t = 0;
      while (!byte_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) chk("rdy_timeout", byte_ready, 1);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (busy && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk("idle_timeout", busy, 0);
   endtask

   task automatic set_nominal(input logic [7:0] ck);
      stream = '{8'h02, 8'h05, 8'h00, 8'h01, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, ck};
      ea = '{5'd0, 5'd1};
      ed = '{32'h2001_0005, 32'h0000_0000};
   endtask

   // Runs a whole load from `stream`; compares RAM writes against ea/ed, returns done count
   task automatic run_load(input string tag, input int gap_max, input bit spam,
                           input bit chk_lat, output int n_done);
      int d0, w0, sc, last;
      w0   = wa_q.size();
      d0   = done_cnt;
      last = stream.size() - 1;
      @(negedge clk);
      start = 1'b1;
      sc    = cyc;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_start_busy"}, busy, 1);
      chk({tag, "_start_rdy"}, byte_ready, 1);
      chk({tag, "_start_err"}, err, 0);
      chk({tag, "_start_hold"}, cpu_hold, 1);
      foreach (stream[i])
         send_byte(stream[i], (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max)),
                   spam && (i == 3 || i == last));
      byte_valid = 1'b0;
      wait_idle();
      if (chk_lat) chk({tag, "_latency"}, done_cyc - sc, 13);
      chk({tag, "_nwr"}, wa_q.size() - w0, ea.size());
      foreach (ea[i]) begin
         if (w0 + i < wa_q.size()) begin
            chk($sformatf("%s_addr%0d", tag, i), wa_q[w0+i], ea[i]);
            chk($sformatf("%s_data%0d", tag, i), wd_q[w0+i], ed[i]);
         end
      end
      n_done = done_cnt - d0;
   endtask

   initial begin
      int nd, w0;
      logic [7:0]  cs;
      logic [31:0] d;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_hold", cpu_hold, 1);
      chk("rst_rdy", byte_ready, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      rst = 1'b0;
      @(negedge clk);

      // Nominal 2-word load with exact latency
      set_nominal(8'h24);
      run_load("nom", 0, 1'b0, 1'b1, nd);
      chk("nom_done", nd, 1);
      chk("nom_hold", cpu_hold, 0);
      chk("nom_err", err, 0);

      // Bad checksum: writes still happen, err sticks, CPU stays held
      set_nominal(8'h25);
      run_load("bad", 0, 1'b0, 1'b0, nd);
      chk("bad_done", nd, 0);
      chk("bad_err", err, 1);
      chk("bad_hold", cpu_hold, 1);
      chk("bad_busy", busy, 0);

      // Full depth: count 0 -> 32 words, word i = i, XOR of 0..31 is 0
      stream.delete(); ea.delete(); ed.delete();
      stream.push_back(8'h00);
      for (int i = 0; i < 32; i++) begin
         stream.push_back(8'(i));
         stream.push_back(8'h00);
         stream.push_back(8'h00);
         stream.push_back(8'h00);
         ea.push_back(5'(i));
         ed.push_back(32'(i));
      end
      stream.push_back(8'h00);
      run_load("full", 0, 1'b0, 1'b0, nd);
      chk("full_done", nd, 1);
      chk("full_err", err, 0);
      chk("full_hold", cpu_hold, 0);

      // Random gaps with random word data
      for (int r = 0; r < 3; r++) begin
         stream.delete(); ea.delete(); ed.delete();
         stream.push_back(8'h03);
         cs = 8'h00;
         for (int w = 0; w < 3; w++) begin
            d = $urandom;
            for (int k = 0; k < 4; k++) begin
               stream.push_back(d[8*k +: 8]);
               cs = cs ^ d[8*k +: 8];
            end
            ea.push_back(5'(w));
            ed.push_back(d);
         end
         stream.push_back(cs);
         run_load($sformatf("gap%0d", r), 3, 1'b0, 1'b0, nd);
         chk($sformatf("gap%0d_done", r), nd, 1);
      end

      // Reset after 6 accepted bytes (one word written, second in progress)
      set_nominal(8'h24);
      w0 = wa_q.size();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 6; i++) send_byte(stream[i], 0, 1'b0);
      byte_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_busy", busy, 0);
      chk("mrst_hold", cpu_hold, 1);
      chk("mrst_err", err, 0);
      chk("mrst_done", done, 0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("mrst_nwr", wa_q.size() - w0, 1);
      run_load("post", 0, 1'b0, 1'b0, nd);
      chk("post_done", nd, 1);
      chk("post_hold", cpu_hold, 0);

      // Stray starts during DATA and CHECK are ignored
      set_nominal(8'h24);
      run_load("spam", 0, 1'b1, 1'b0, nd);
      chk("spam_done", nd, 1);
      chk("spam_err", err, 0);
      repeat (3) @(negedge clk);
      chk("spam_idle", busy, 0);

      chk("rdy_in_write", rdy_viol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
